// File: rtl/btn_event_ctrl.sv
// Button event controller: per-button short/long press classification, fixed-priority
// arbitration into a show-ahead event FIFO. Optional auto-repeat: define BTN_REPEAT_EN.
module btn_event_ctrl #(
    parameter int N_BTN         = 4,
    parameter int LONG_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn_in,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_long,
    output logic                     evt_repeat,
    output logic                     overflow
);

    localparam int IDW = $clog2(N_BTN);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(LONG_CYCLES);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(DEPTH);
`ifdef BTN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_t;

    logic [N_BTN-1:0] sync1_r, sync2_r, prev_r;
    logic [N_BTN-1:0] rise_s, fall_s;
    logic [N_BTN-1:0] set_vec_s, set_long_vec_s;
    logic [N_BTN-1:0] pend_v_r, pend_long_r;
    logic [N_BTN-1:0] sel_oh_s, grant_s, drop_s;
    logic [IDW-1:0]   sel_id_s;
    logic             sel_found_s;
    logic             push_s, pop_s, full_s;
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [AW:0]      count_r, count_nxt_s;
    logic             valid_r, overflow_r;
    logic [IDW-1:0]   mem_id_r   [DEPTH];
    logic             mem_long_r [DEPTH];
`ifdef BTN_REPEAT_EN
    logic [N_BTN-1:0] set_rep_vec_s, pend_rep_r;
    logic             mem_rep_r  [DEPTH];
`endif

    // Two-flop synchronizer plus a history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
            prev_r  <= '0;
        end else begin
            sync1_r <= btn_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign rise_s = sync2_r & ~prev_r;
    assign fall_s = ~sync2_r & prev_r;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        btn_state_t    state_r, state_nxt_s;
        logic [CW-1:0] hold_cnt_r;
        logic          tick_s, set_s, long_s;

        // State register and hold counter
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r    <= ST_IDLE;
                hold_cnt_r <= '0;
            end else begin
                state_r <= state_nxt_s;
                if (state_r == ST_PRESSED && state_nxt_s == ST_PRESSED) begin
                    hold_cnt_r <= hold_cnt_r + CW'(1);
                end else begin
                    hold_cnt_r <= '0;
                end
            end
        end

`ifdef BTN_REPEAT_EN
        logic [RW-1:0] rep_cnt_r;

        // Repeat counter runs only while held, wrapping every REPEAT_CYCLES
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rep_cnt_r <= '0;
            end else if (state_r == ST_HELD && state_nxt_s == ST_HELD) begin
                rep_cnt_r <= (rep_cnt_r == REP_LAST) ? '0 : rep_cnt_r + RW'(1);
            end else begin
                rep_cnt_r <= '0;
            end
        end

        assign tick_s = (state_r == ST_HELD) && !fall_s[gi] && (rep_cnt_r == REP_LAST);
        assign set_rep_vec_s[gi] = tick_s;
`else
        assign tick_s = 1'b0;
`endif

        // Next-state logic; a release on the threshold cycle stays a short press
        always_comb begin
            state_nxt_s = state_r;
            case (state_r)
                ST_IDLE: begin
                    if (rise_s[gi]) state_nxt_s = ST_PRESSED;
                    else            state_nxt_s = ST_IDLE;
                end
                ST_PRESSED: begin
                    if (fall_s[gi])                    state_nxt_s = ST_IDLE;
                    else if (hold_cnt_r == LONG_LAST)  state_nxt_s = ST_HELD;
                    else                               state_nxt_s = ST_PRESSED;
                end
                ST_HELD: begin
                    if (fall_s[gi]) state_nxt_s = ST_IDLE;
                    else            state_nxt_s = ST_HELD;
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end

        // Event generation toward the pending slot
        always_comb begin
            set_s  = 1'b0;
            long_s = 1'b0;
            case (state_r)
                ST_PRESSED: begin
                    if (fall_s[gi]) begin
                        set_s  = 1'b1;
                        long_s = 1'b0;
                    end else if (hold_cnt_r == LONG_LAST) begin
                        set_s  = 1'b1;
                        long_s = 1'b1;
                    end else begin
                        set_s  = 1'b0;
                        long_s = 1'b0;
                    end
                end
                ST_HELD: begin
                    if (tick_s) begin
                        set_s  = 1'b1;
                        long_s = 1'b1;
                    end else begin
                        set_s  = 1'b0;
                        long_s = 1'b0;
                    end
                end
                default: begin
                    set_s  = 1'b0;
                    long_s = 1'b0;
                end
            endcase
        end

        assign set_vec_s[gi]      = set_s;
        assign set_long_vec_s[gi] = long_s;
    end

    // A slot that is still valid (even if granted this cycle) rejects new events
    assign drop_s = set_vec_s & pend_v_r;

    // Pending slots: one event per button waiting for a FIFO write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_r    <= '0;
            pend_long_r <= '0;
`ifdef BTN_REPEAT_EN
            pend_rep_r  <= '0;
`endif
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (grant_s[i]) begin
                    pend_v_r[i] <= 1'b0;
                end else if (set_vec_s[i] && !pend_v_r[i]) begin
                    pend_v_r[i]    <= 1'b1;
                    pend_long_r[i] <= set_long_vec_s[i];
`ifdef BTN_REPEAT_EN
                    pend_rep_r[i]  <= set_rep_vec_s[i];
`endif
                end else begin
                    pend_v_r[i] <= pend_v_r[i];
                end
            end
        end
    end

    // Fixed-priority select: lowest index wins
    always_comb begin
        sel_oh_s    = '0;
        sel_id_s    = '0;
        sel_found_s = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (pend_v_r[i] && !sel_found_s) begin
                sel_found_s = 1'b1;
                sel_id_s    = IDW'(i);
                sel_oh_s[i] = 1'b1;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    assign full_s  = (count_r == FIFO_FULL);
    assign pop_s   = valid_r && evt_ready;
    assign push_s  = sel_found_s && (!full_s || pop_s);
    assign grant_s = push_s ? sel_oh_s : '0;

    // Occupancy update
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + (AW+1)'(1);
            2'b01:   count_nxt_s = count_r - (AW+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage, pointers and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_id_r[i]   <= '0;
                mem_long_r[i] <= 1'b0;
`ifdef BTN_REPEAT_EN
                mem_rep_r[i]  <= 1'b0;
`endif
            end
        end else begin
            if (push_s) begin
                mem_id_r[wr_ptr_r]   <= sel_id_s;
                mem_long_r[wr_ptr_r] <= pend_long_r[sel_id_s];
`ifdef BTN_REPEAT_EN
                mem_rep_r[wr_ptr_r]  <= pend_rep_r[sel_id_s];
`endif
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r    <= count_nxt_s;
            valid_r    <= (count_nxt_s != '0);
            overflow_r <= |drop_s;
        end
    end

    assign evt_valid = valid_r;
    assign evt_id    = mem_id_r[rd_ptr_r];
    assign evt_long  = mem_long_r[rd_ptr_r];
    assign overflow  = overflow_r;
`ifdef BTN_REPEAT_EN
    assign evt_repeat = mem_rep_r[rd_ptr_r];
`else
    assign evt_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed self-checking bench for btn_event_ctrl (N_BTN=4, LONG=16, REPEAT=8, DEPTH=4).
module tb_btn_event_ctrl;

    localparam int N_BTN         = 4;
    localparam int LONG_CYCLES   = 16;
    localparam int REPEAT_CYCLES = 8;
    localparam int DEPTH         = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_in = 4'd0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_long;
    logic       evt_repeat;
    logic       overflow;

    int total = 0;
    int bad = 0;
    int ovf_cnt = 0;

    btn_event_ctrl #(
        .N_BTN(N_BTN), .LONG_CYCLES(LONG_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_long(evt_long), .evt_repeat(evt_repeat), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Counts cycles with overflow high, sampled shortly after each rising edge
    always @(posedge clk) begin
        #2;
        if (overflow === 1'b1) ovf_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int idx, input int hold, input int gap);
        btn_in[idx] = 1'b1;
        step(hold);
        btn_in[idx] = 1'b0;
        step(gap);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", evt_valid); end
        total++; if (evt_id !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", evt_id); end
        total++; if (evt_long !== 1'b0) begin bad++; $display("FAIL reset_long: got %0b want 0", evt_long); end
        total++; if (evt_repeat !== 1'b0) begin bad++; $display("FAIL reset_repeat: got %0b want 0", evt_repeat); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        rst_n = 1'b1;
        step(3);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid: got %0b want 0", evt_valid); end
    endtask

    task automatic test_short();
        int ovf0;
        ovf0 = ovf_cnt;
        evt_ready = 1'b1;
        btn_in[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL short_during_press: got %0b want 0", evt_valid); end
        end
        btn_in[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL short_latency_e%0d: got %0b want 0", k, evt_valid); end
        end
        step(1);
        total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL short_valid: got %0b want 1", evt_valid); end
        total++; if (evt_id !== 2'd2) begin bad++; $display("FAIL short_id: got %0d want 2", evt_id); end
        total++; if (evt_long !== 1'b0) begin bad++; $display("FAIL short_long: got %0b want 0", evt_long); end
        total++; if (evt_repeat !== 1'b0) begin bad++; $display("FAIL short_repeat: got %0b want 0", evt_repeat); end
        step(1);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL short_popped: got %0b want 0", evt_valid); end
        total++; if (ovf_cnt !== ovf0) begin bad++; $display("FAIL short_overflow: got %0d want %0d", ovf_cnt, ovf0); end
    endtask

    task automatic test_long();
        int early;
        int extra;
        int reps;
        int exp_extra;
`ifdef BTN_REPEAT_EN
        exp_extra = 2;
`else
        exp_extra = 0;
`endif
        early = 0; extra = 0; reps = 0;
        evt_ready = 1'b1;
        btn_in[1] = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            step(1);
            if (evt_valid !== 1'b0) early++;
        end
        total++; if (early !== 0) begin bad++; $display("FAIL long_early: got %0d want 0", early); end
        step(1);
        total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL long_valid: got %0b want 1", evt_valid); end
        total++; if (evt_id !== 2'd1) begin bad++; $display("FAIL long_id: got %0d want 1", evt_id); end
        total++; if (evt_long !== 1'b1) begin bad++; $display("FAIL long_long: got %0b want 1", evt_long); end
        total++; if (evt_repeat !== 1'b0) begin bad++; $display("FAIL long_repeat: got %0b want 0", evt_repeat); end
        for (int k = 21; k <= 52; k++) begin
            step(1);
            if (evt_valid === 1'b1) begin
                extra++;
                if (evt_repeat === 1'b1 && evt_long === 1'b1 && evt_id === 2'd1) reps++;
            end
            if (k == 40) btn_in[1] = 1'b0;
        end
        total++; if (extra !== exp_extra) begin bad++; $display("FAIL long_extra_events: got %0d want %0d", extra, exp_extra); end
        total++; if (reps !== exp_extra) begin bad++; $display("FAIL long_repeat_events: got %0d want %0d", reps, exp_extra); end
    endtask

    task automatic test_simultaneous();
        evt_ready = 1'b0;
        btn_in = 4'b1001;
        step(5);
        btn_in = 4'b0000;
        step(3);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL simul_early: got %0b want 0", evt_valid); end
        step(1);
        total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL simul_valid: got %0b want 1", evt_valid); end
        total++; if (evt_id !== 2'd0) begin bad++; $display("FAIL simul_first: got %0d want 0", evt_id); end
        step(1);
        total++; if (evt_id !== 2'd0) begin bad++; $display("FAIL simul_stable: got %0d want 0", evt_id); end
        evt_ready = 1'b1;
        step(1);
        total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL simul_second_valid: got %0b want 1", evt_valid); end
        total++; if (evt_id !== 2'd3) begin bad++; $display("FAIL simul_second: got %0d want 3", evt_id); end
        step(1);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL simul_empty: got %0b want 0", evt_valid); end
        evt_ready = 1'b0;
    endtask

    task automatic test_full_fifo();
        int ovf0;
        int exp_ids [6];
        exp_ids = '{0, 1, 2, 3, 0, 1};
        ovf0 = ovf_cnt;
        evt_ready = 1'b0;
        for (int k = 0; k < 6; k++) press(exp_ids[k], 3, 3);
        step(6);
        total++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin bad++; $display("FAIL full_head: got valid=%0b id=%0d want valid=1 id=0", evt_valid, evt_id); end
        total++; if (ovf_cnt !== ovf0) begin bad++; $display("FAIL full_overflow: got %0d want %0d", ovf_cnt, ovf0); end
        evt_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            total++;
            if (evt_valid !== 1'b1 || evt_id !== 2'(exp_ids[k]) || evt_long !== 1'b0) begin
                bad++;
                $display("FAIL full_drain_%0d: got valid=%0b id=%0d long=%0b want valid=1 id=%0d long=0", k, evt_valid, evt_id, evt_long, exp_ids[k]);
            end
            step(1);
        end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL full_empty: got %0b want 0", evt_valid); end
        evt_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int ovf0;
        int exp_ids [5];
        exp_ids = '{0, 1, 2, 3, 0};
        ovf0 = ovf_cnt;
        evt_ready = 1'b0;
        for (int k = 0; k < 5; k++) press(exp_ids[k], 3, 3);
        step(6);
        total++; if (ovf_cnt !== ovf0) begin bad++; $display("FAIL ovf_none_yet: got %0d want %0d", ovf_cnt, ovf0); end
        press(0, 3, 3);
        step(6);
        total++; if (ovf_cnt !== ovf0 + 1) begin bad++; $display("FAIL ovf_pulse: got %0d want %0d", ovf_cnt, ovf0 + 1); end
        evt_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (evt_valid !== 1'b1 || evt_id !== 2'(exp_ids[k])) begin
                bad++;
                $display("FAIL ovf_drain_%0d: got valid=%0b id=%0d want valid=1 id=%0d", k, evt_valid, evt_id, exp_ids[k]);
            end
            step(1);
        end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %0b want 0", evt_valid); end
        evt_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b0;
        press(1, 3, 3);
        press(2, 3, 3);
        press(3, 3, 3);
        step(6);
        total++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin bad++; $display("FAIL rstmid_queued: got valid=%0b id=%0d want valid=1 id=1", evt_valid, evt_id); end
        rst_n = 1'b0;
        #1;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %0b want 0", evt_valid); end
        total++; if (evt_id !== 2'd0) begin bad++; $display("FAIL rstmid_id: got %0d want 0", evt_id); end
        total++; if (evt_long !== 1'b0 || evt_repeat !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL rstmid_flags: got long=%0b rep=%0b ovf=%0b want 0", evt_long, evt_repeat, overflow); end
        step(2);
        rst_n = 1'b1;
        step(10);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rstmid_after: got %0b want 0", evt_valid); end
        press(2, 3, 0);
        step(4);
        total++; if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin bad++; $display("FAIL rstmid_new: got valid=%0b id=%0d want valid=1 id=2", evt_valid, evt_id); end
        evt_ready = 1'b1;
        step(2);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rstmid_drain: got %0b want 0", evt_valid); end
        evt_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_simultaneous();
        test_full_fifo();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_event_ctrl.md
# btn_event_ctrl

Button event controller that sits between the per-button debouncers and the game/menu logic. It watches N debounced button lines and classifies each press as short or long. Simultaneous events from different buttons are arbitrated by fixed priority, and accepted events are queued in a small FIFO. Consumers read events through a valid/ready handshake, so no press is lost while the consumer is busy.

## Interface

Parameters:
- N_BTN, 4: number of button lines; 2..8.
- LONG_CYCLES, 25_000_000: hold length in clk cycles that qualifies a press as long; ≥ 4.
- REPEAT_CYCLES, 10_000_000: auto-repeat period in cycles, used only with BTN_REPEAT_EN; ≥ 2.
- DEPTH, 4: event FIFO depth; power of two, 2..16.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- btn_in, input, N_BTN: debounced button levels, active-high, asynchronous to clk.
- evt_valid, output, 1: FIFO head holds an event.
- evt_ready, input, 1: consumer accepts the head; a pop occurs when evt_valid && evt_ready.
- evt_id, output, clog2(N_BTN): index of the button for the head event.
- evt_long, output, 1: head event is long (1) or short (0).
- evt_repeat, output, 1: head event is an auto-repeat; tied 0 without BTN_REPEAT_EN.
- overflow, output, 1: one-cycle pulse when an event is dropped.

## Operation

- Each btn_in bit passes through a 2-flop synchronizer. A third flop holds the previous synchronized level for edge detection.
- Each button has its own FSM:
  - IDLE: on a rising synchronized edge, go to PRESSED and clear the hold counter.
  - PRESSED: the counter increments every cycle.
    - Falling edge: set pending(short), go to IDLE.
    - Counter == LONG_CYCLES-1 while still high: set pending(long), go to HELD.
    - Release on the threshold cycle: release wins, so the event is short.
  - HELD: on a falling edge, go to IDLE and emit no event.
- Pending slot: one per button, holding a valid bit plus kind bits.
  - If a new event arrives while the slot is still valid, the new event is dropped and overflow pulses.
- Arbiter: each cycle, the lowest-index valid pending slot is written to the FIFO if a push is allowed, and that slot is cleared.
  - Push is allowed when the FIFO is not full, or when a pop happens in the same cycle.
  - Pending slots of other buttons keep waiting; they are never dropped for arbitration reasons.
- FIFO: show-ahead, DEPTH entries, with wrap-around read and write pointers plus a count.
  - When full, writes stall and events accumulate in the pending slots.
  - Push and pop in the same cycle are allowed at any occupancy. When empty, push and pop in the same cycle are impossible because evt_valid is 0.
  - The evt_* outputs come directly from the head entry.
- overflow pulses at most once per cycle, even if several buttons drop events in the same cycle.

## Timing

- Reset values: evt_valid=0, evt_id=0, evt_long=0, evt_repeat=0, overflow=0. FSMs go to IDLE, pending slots are cleared, the FIFO is empty and the synchronizers are 0.
- A button held across reset release is seen as a fresh press.
- Reset asserted mid-operation clears everything immediately; queued events are lost.
- Short event latency, with the FIFO empty and no higher-priority pending:
  - E0: first edge that samples the falling btn_in.
  - E2: pending is set.
  - E3: FIFO write; evt_valid is high after E3.
- Long event: pending(long) is set LONG_CYCLES cycles after the FSM enters PRESSED. evt_valid follows 1 cycle later if the FIFO is empty.
- evt_valid stays high, with stable evt_* outputs, until the pop.
- After a pop, the next entry appears on the following cycle with no bubble.

## Configuration

- BTN_REPEAT_EN defined:
  - In HELD, a repeat counter starts at 0 on entry.
  - Each time it reaches REPEAT_CYCLES-1 it wraps and sets pending(long, repeat).
  - Repeats go through the same pending, overflow and arbitration rules.
- BTN_REPEAT_EN undefined: no repeat counter is built, HELD only waits for release, and evt_repeat is constant 0.

## Test plan

All scenarios use N_BTN=4, LONG_CYCLES=16, REPEAT_CYCLES=8, DEPTH=4.

- Short press: btn_in[2] high for 5 cycles, evt_ready=1 -> one event {id=2, long=0}; evt_valid high after the 3rd edge past release; no overflow.
- Long press: btn_in[1] high for 40 cycles -> exactly one {id=1, long=1}, about 17 cycles after the press is detected; release produces no event. With BTN_REPEAT_EN: additional {id=1, long=1, repeat=1} events every 8 cycles while held.
- Simultaneous: btn_in[3] and btn_in[0] released on the same edge -> id=0 queued first, id=3 on the next cycle.
- Full FIFO: evt_ready=0, with 6 short presses spread across buttons 0..3 -> 4 entries queued, the rest held in pending. Raising evt_ready drains all 6 in priority/arrival order.
- Overflow: evt_ready=0, FIFO full, button 0 pending; press and release button 0 again -> overflow pulses for 1 cycle and the queued contents are unchanged.
- Reset mid-operation: assert rst_n=0 with 3 queued events -> all outputs 0 immediately; after release, evt_valid stays 0 until a new press.
